light_encryptor_param: RTL and testbench

- Parametrised successor to the fixed 640-bit light encryptor.
- Processes NUM_BLOCKS 128-bit blocks per request:
  - confidentiality: CTR mode;
  - integrity: CBC-MAC over the ciphertext (encrypt-then-MAC).
- Supports encrypt and decrypt modes.
- Drives an external 128-bit block-cipher engine over a val/rdy request / val response port, one call outstanding at a time.
- Sits between the shell-side data mover and the shared cipher engine.

---
 rtl/light_encryptor_param.sv | 121 ++++++++++++
 tb/tb_light_encryptor_param.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_encryptor_param.sv
// CTR-mode encryptor/decryptor with encrypt-then-MAC CBC-MAC over NUM_BLOCKS 128-bit blocks.
// Every keystream and MAC step goes through one external block-cipher engine, one call at a time.
module light_encryptor_param #(
    parameter int          NUM_BLOCKS = 5,
    parameter logic [31:0] CTR_INIT   = 32'd1,
    localparam int         DW         = 128 * NUM_BLOCKS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] req_data,
    input  logic [95:0]   req_nonce,
    input  logic          req_mode,
    input  logic          req_val,
    output logic          req_rdy,
    output logic [DW-1:0] resp_data,
    output logic [127:0]  resp_mac,
    output logic          resp_val,
    input  logic          resp_rdy,
    output logic [127:0]  bc_req_data,
    output logic          bc_req_val,
    input  logic          bc_req_rdy,
    input  logic [127:0]  bc_resp_data,
    input  logic          bc_resp_val
);
    typedef enum logic [2:0] {IDLE, KS_REQ, KS_WAIT, MAC_REQ, MAC_WAIT, DONE} state_t;

    state_t        state_q;
    logic [DW-1:0] data_q, resp_data_q;
    logic [95:0]   nonce_q;
    logic          mode_q;
    logic [7:0]    idx_q;
    logic [31:0]   ctr_q;
    logic [127:0]  mac_q, ct_q, resp_mac_q;
    logic          req_rdy_q, resp_val_q, bc_req_val_q;

    logic [14:0]   off;
    logic [127:0]  in_blk, out_blk, ct_d;
    logic          last_blk;

    always_comb begin
        off      = {idx_q, 7'd0};
        in_blk   = data_q[off +: 128];
        out_blk  = in_blk ^ bc_resp_data;
        // The MAC always covers the ciphertext, whichever direction we run.
        ct_d     = mode_q ? in_blk : out_blk;
        last_blk = (idx_q == 8'(NUM_BLOCKS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_rdy_q    <= 1'b1;
            resp_val_q   <= 1'b0;
            bc_req_val_q <= 1'b0;
            resp_data_q  <= '0;
            resp_mac_q   <= '0;
            mac_q        <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            nonce_q      <= '0;
            mode_q       <= 1'b0;
            ctr_q        <= '0;
            ct_q         <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (req_val) begin
                    data_q       <= req_data;
                    nonce_q      <= req_nonce;
                    mode_q       <= req_mode;
                    idx_q        <= '0;
                    mac_q        <= '0;
                    ctr_q        <= CTR_INIT;
                    req_rdy_q    <= 1'b0;
                    bc_req_val_q <= 1'b1;
                    state_q      <= KS_REQ;
                end
                KS_REQ: if (bc_req_rdy) begin
                    bc_req_val_q <= 1'b0;
                    state_q      <= KS_WAIT;
                end
                KS_WAIT: if (bc_resp_val) begin
                    resp_data_q[off +: 128] <= out_blk;
                    ct_q         <= ct_d;
                    bc_req_val_q <= 1'b1;
                    state_q      <= MAC_REQ;
                end
                MAC_REQ: if (bc_req_rdy) begin
                    bc_req_val_q <= 1'b0;
                    state_q      <= MAC_WAIT;
                end
                MAC_WAIT: if (bc_resp_val) begin
                    mac_q <= bc_resp_data;
                    if (last_blk) begin
                        resp_mac_q <= bc_resp_data;
                        resp_val_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        idx_q        <= idx_q + 8'd1;
                        ctr_q        <= ctr_q + 32'd1;
                        bc_req_val_q <= 1'b1;
                        state_q      <= KS_REQ;
                    end
                end
                DONE: if (resp_rdy) begin
                    resp_val_q <= 1'b0;
                    req_rdy_q  <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Built only from registers, so the engine sees a stable word while it stalls.
    assign bc_req_data = (state_q == MAC_REQ) ? (mac_q ^ ct_q) : {nonce_q, ctr_q};
    assign bc_req_val  = bc_req_val_q;
    assign req_rdy     = req_rdy_q;
    assign resp_val    = resp_val_q;
    assign resp_data   = resp_data_q;
    assign resp_mac    = resp_mac_q;
endmodule

// File: tb/tb_light_encryptor_param.sv
// Scoreboard bench: three DUT configurations, each with its own engine stub (E(x)=x or ~x, latency L).
module tb_light_encryptor_param;
    localparam int L = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [255:0] req_data;
    logic [95:0]  req_nonce;
    logic         req_mode;
    logic [2:0]   req_val, req_rdy, resp_val, resp_rdy, bc_req_val, bc_req_rdy, bc_resp_val;
    logic [127:0] rd0;
    logic [255:0] rd1, rd2;
    logic [127:0] resp_mac [3];
    logic [127:0] bc_req_data [3];
    logic [127:0] bc_resp_data [3];

    light_encryptor_param #(.NUM_BLOCKS(1), .CTR_INIT(32'd1)) u_n1 (
        .clk(clk), .rst(rst), .req_data(req_data[127:0]), .req_nonce(req_nonce), .req_mode(req_mode),
        .req_val(req_val[0]), .req_rdy(req_rdy[0]), .resp_data(rd0), .resp_mac(resp_mac[0]),
        .resp_val(resp_val[0]), .resp_rdy(resp_rdy[0]), .bc_req_data(bc_req_data[0]),
        .bc_req_val(bc_req_val[0]), .bc_req_rdy(bc_req_rdy[0]), .bc_resp_data(bc_resp_data[0]),
        .bc_resp_val(bc_resp_val[0]));

    light_encryptor_param #(.NUM_BLOCKS(2), .CTR_INIT(32'd1)) u_n2 (
        .clk(clk), .rst(rst), .req_data(req_data), .req_nonce(req_nonce), .req_mode(req_mode),
        .req_val(req_val[1]), .req_rdy(req_rdy[1]), .resp_data(rd1), .resp_mac(resp_mac[1]),
        .resp_val(resp_val[1]), .resp_rdy(resp_rdy[1]), .bc_req_data(bc_req_data[1]),
        .bc_req_val(bc_req_val[1]), .bc_req_rdy(bc_req_rdy[1]), .bc_resp_data(bc_resp_data[1]),
        .bc_resp_val(bc_resp_val[1]));

    light_encryptor_param #(.NUM_BLOCKS(2), .CTR_INIT(32'hFFFF_FFFF)) u_wrap (
        .clk(clk), .rst(rst), .req_data(req_data), .req_nonce(req_nonce), .req_mode(req_mode),
        .req_val(req_val[2]), .req_rdy(req_rdy[2]), .resp_data(rd2), .resp_mac(resp_mac[2]),
        .resp_val(resp_val[2]), .resp_rdy(resp_rdy[2]), .bc_req_data(bc_req_data[2]),
        .bc_req_val(bc_req_val[2]), .bc_req_rdy(bc_req_rdy[2]), .bc_resp_data(bc_resp_data[2]),
        .bc_resp_val(bc_resp_val[2]));

    typedef struct {
        int           inst;
        logic [255:0] data;
        logic [127:0] mac;
        int           lat;
    } sb_t;
    sb_t sb[$];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    bit inv = 1'b0;
    int stall_n = 0;
    int rdy_delay = 0;

    int           pend_cnt [3], wait_cnt [3], hs_cnt [3], hold_cnt [3];
    logic [127:0] pend_dat [3], prev_bcd [3], prev_mac [3], last_mac [3];
    logic [255:0] prev_rd [3], last_data [3];
    bit           prev_stall [3], prev_rv [3], prev_hold [3];

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    function automatic int nblk(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic logic [255:0] rdat(input int i);
        case (i)
            0:       return 256'(rd0);
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: CTR keystream E({nonce,ctr}), CBC-MAC over ciphertext blocks.
    function automatic void model(input int n, input logic [31:0] ci, input bit iv, input bit md,
                                  input logic [255:0] din, input logic [95:0] nc,
                                  output logic [255:0] dout, output logic [127:0] mac);
        logic [31:0]  c;
        logic [127:0] ks, o, ct;
        c = ci; dout = '0; mac = '0;
        for (int b = 0; b < n; b++) begin
            ks = iv ? ~{nc, c} : {nc, c};
            o  = din[b*128 +: 128] ^ ks;
            dout[b*128 +: 128] = o;
            ct  = md ? din[b*128 +: 128] : o;
            mac = iv ? ~(mac ^ ct) : (mac ^ ct);
            c   = c + 32'd1;
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Engine stubs and response sink; everything here is decided at the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                pend_cnt[i] = 0; wait_cnt[i] = 0; hs_cnt[i] = 0; hold_cnt[i] = 0;
                prev_stall[i] = 0; prev_rv[i] = 0; prev_hold[i] = 0;
                bc_resp_val[i] = 1'b0; bc_resp_data[i] = '0; bc_req_rdy[i] = 1'b0; resp_rdy[i] = 1'b0;
            end else begin
                bc_resp_val[i] = 1'b0;
                if (pend_cnt[i] > 0) begin
                    pend_cnt[i]--;
                    if (pend_cnt[i] == 0) begin
                        bc_resp_val[i]  = 1'b1;
                        bc_resp_data[i] = pend_dat[i];
                    end
                end
                if (prev_stall[i])
                    chk("bc_req_held", {127'd0, bc_req_val[i], bc_req_data[i]}, {127'd0, 1'b1, prev_bcd[i]});
                if (bc_req_val[i]) begin
                    chk("one_outstanding", 256'((pend_cnt[i] != 0) || bc_resp_val[i]), 256'd0);
                    bc_req_rdy[i] = (wait_cnt[i] >= stall_n);
                    if (bc_req_rdy[i]) begin
                        wait_cnt[i] = 0; hs_cnt[i]++; pend_cnt[i] = L; prev_stall[i] = 0;
                        pend_dat[i] = inv ? ~bc_req_data[i] : bc_req_data[i];
                    end else begin
                        wait_cnt[i]++; prev_stall[i] = 1; prev_bcd[i] = bc_req_data[i];
                    end
                end else begin
                    bc_req_rdy[i] = 1'b0; prev_stall[i] = 0;
                end

                if (resp_val[i]) begin
                    if (!prev_rv[i] && sb.size() != 0 && sb[0].inst == i && sb[0].lat != 0)
                        chk("latency", 256'(cyc + 1 - acc_cyc), 256'(sb[0].lat));
                    if (prev_hold[i]) begin
                        chk("resp_data_hold", rdat(i), prev_rd[i]);
                        chk("resp_mac_hold", 256'(resp_mac[i]), 256'(prev_mac[i]));
                    end
                    resp_rdy[i] = (hold_cnt[i] >= rdy_delay);
                    if (resp_rdy[i]) begin
                        if (sb.size() != 0 && sb[0].inst == i) begin
                            sb_t e;
                            e = sb.pop_front();
                            chk("resp_data", rdat(i), e.data);
                            chk("resp_mac", 256'(resp_mac[i]), 256'(e.mac));
                            chk("engine_calls", 256'(hs_cnt[i]), 256'(2 * nblk(i)));
                            last_data[i] = rdat(i); last_mac[i] = resp_mac[i];
                        end else begin
                            chk("spurious_resp", 256'(resp_val[i]), 256'd0);
                        end
                        hs_cnt[i] = 0; hold_cnt[i] = 0; prev_hold[i] = 0;
                    end else begin
                        hold_cnt[i]++; prev_hold[i] = 1;
                        prev_rd[i] = rdat(i); prev_mac[i] = resp_mac[i];
                    end
                end else begin
                    resp_rdy[i] = 1'b0; prev_hold[i] = 0;
                end
                prev_rv[i] = resp_val[i];
            end
        end
    end

    task automatic chk_reset(input int i);
        chk("rst_req_rdy", 256'(req_rdy[i]), 256'd1);
        chk("rst_resp_val", 256'(resp_val[i]), 256'd0);
        chk("rst_bc_req_val", 256'(bc_req_val[i]), 256'd0);
        chk("rst_resp_data", rdat(i), 256'd0);
        chk("rst_resp_mac", 256'(resp_mac[i]), 256'd0);
    endtask

    // Entered and left just after a rising edge.
    task automatic send(input int i, input bit md, input logic [255:0] d, input logic [95:0] n,
                        input logic [255:0] ed, input logic [127:0] em, input int lat, input bit linger);
        bit acc;
        sb.push_back('{i, ed, em, lat});
        req_mode = md; req_data = d; req_nonce = n; req_val[i] = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = req_rdy[i];
            @(posedge clk); #2;
        end
        acc_cyc = cyc;
        if (!acc) begin
            chk("req_accept", 256'(req_rdy[i]), 256'd1);
            void'(sb.pop_back());
        end
        // Inputs may change after acceptance; a lingering req_val must be ignored while busy.
        req_data = rnd256(); req_nonce = rnd256()[95:0]; req_mode = ~md;
        if (linger) repeat (4) begin @(posedge clk); #2; end
        req_val[i] = 1'b0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 400 && sb.size() != 0; t++) begin @(posedge clk); #2; end
        if (sb.size() != 0) begin
            chk("timeout", 256'(sb.size()), 256'd0);
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d, ed, ct;
        logic [127:0] em;
        logic [95:0]  n;
        rst = 1'b1; req_val = '0; req_data = '0; req_nonce = '0; req_mode = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) chk_reset(i);
        rst = 1'b0;

        send(0, 1'b0, '0, '0, 256'h1, 128'h1, 7, 1'b1);
        wait_done();
        send(1, 1'b0, '0, '0, {128'h2, 128'h1}, 128'h3, 13, 1'b1);
        wait_done();
        send(1, 1'b1, {128'h2, 128'h1}, '0, '0, 128'h3, 13, 1'b0);
        wait_done();
        send(2, 1'b0, '0, '0, {128'h0, 128'hFFFF_FFFF}, 128'hFFFF_FFFF, 13, 1'b0);
        wait_done();

        inv = 1'b1;
        d = rnd256(); n = rnd256()[95:0];
        model(1, 32'd1, 1'b1, 1'b0, d, n, ed, em);
        send(0, 1'b0, d, n, ed, em, 7, 1'b0);
        wait_done();
        for (int r = 0; r < 3; r++) begin
            d = rnd256(); n = rnd256()[95:0];
            model(2, 32'd1, 1'b1, 1'b0, d, n, ed, em);
            send(1, 1'b0, d, n, ed, em, 13, 1'b0);
            wait_done();
            ct = last_data[1];
            send(1, 1'b1, ct, n, d, em, 13, 1'b0);
            wait_done();
        end

        inv = 1'b0; stall_n = 4; rdy_delay = 3;
        d = rnd256(); n = rnd256()[95:0];
        model(2, 32'd1, 1'b0, 1'b0, d, n, ed, em);
        send(1, 1'b0, d, n, ed, em, 0, 1'b0);
        wait_done();
        stall_n = 0; rdy_delay = 0;

        send(1, 1'b0, '0, '0, {128'h2, 128'h1}, 128'h3, 13, 1'b0);
        for (int t = 0; t < 100 && hs_cnt[1] != 3; t++) begin @(posedge clk); #2; end
        chk("abort_reach_ks_wait", 256'(hs_cnt[1]), 256'd3);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #2;
        chk_reset(1);
        rst = 1'b0;
        repeat (20) begin @(posedge clk); #2; end
        chk("abort_no_resp", 256'(resp_val[1]), 256'd0);
        send(1, 1'b0, '0, '0, {128'h2, 128'h1}, 128'h3, 13, 1'b0);
        wait_done();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
